// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, constants and the IF/ID pipeline record
// Contents: ADDR_W, INSTR_W, NOP_INSTR, PC_STEP, if_id_t, IF_ID_BUBBLE, align_word()
package cpu_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

   // IF/ID pipeline register contents; decode consumes the same record.
   typedef struct packed {
      logic [ADDR_W-1:0]  pc4;
      logic [INSTR_W-1:0] instr;
      logic               valid;
   } if_id_t;

   // A bubble carries a NOP, a zero PC+4 and is marked invalid.
   localparam if_id_t IF_ID_BUBBLE = '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};

   // Force an address onto a word boundary by dropping the byte offset.
   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with next-PC selection
// Ports: clk_i, rst_i (sync, active-high), stall_i, branch_taken_i,
//        branch_target_i[31:0], pc_o[31:0] (the PC register itself)
module fetch_pc_reg
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_next;

   // A branch beats a stall so a redirect is never lost behind a hazard.
   // The increment wraps silently at the top of the address space.
   always_comb begin
      pc_next = pc_q + PC_STEP;
      if (branch_taken_i) begin
         pc_next = align_word(branch_target_i);
      end else if (stall_i) begin
         pc_next = pc_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   // Memory address comes straight off the flop.
   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, fetch counter
// Ports: clk_i, rst_i (sync, active-high), stall_i, flush_i, branch_taken_i,
//        branch_target_i[31:0], instr_i[31:0] (async memory data for pc_addr_o),
//        pc_addr_o[31:0], if_id_pc4_o[31:0], if_id_instr_o[31:0], if_id_valid_o,
//        fetch_count_o[CNT_W-1:0]
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter int                MEM_WORDS = 32,
   parameter int                CNT_W     = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic               branch_taken_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [ADDR_W-1:0]  pc_addr_o,
   output logic [ADDR_W-1:0]  if_id_pc4_o,
   output logic [INSTR_W-1:0] if_id_instr_o,
   output logic               if_id_valid_o,
   output logic [CNT_W-1:0]   fetch_count_o
);

   localparam logic [ADDR_W-3:0] MEM_WORDS_L = (ADDR_W-2)'(MEM_WORDS);
   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              in_range;
   logic              kill;
   logic              load_valid;
   if_id_t            if_id_q;
   logic [CNT_W-1:0]  count_q;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .pc_o            (pc)
   );

   assign pc_plus4 = pc + PC_STEP;

   // Words past the end of memory return undefined data; replace with a bubble.
   assign in_range = (pc[ADDR_W-1:2] < MEM_WORDS_L);

   // A redirect or flush squashes whatever is being fetched, even under stall.
   assign kill = branch_taken_i | flush_i;

   assign load_valid = ~kill & ~stall_i & in_range;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         if_id_q <= IF_ID_BUBBLE;
      end else if (kill) begin
         if_id_q <= IF_ID_BUBBLE;
      end else if (!stall_i) begin
         if (in_range) begin
            if_id_q <= '{pc4: pc_plus4, instr: instr_i, valid: 1'b1};
         end else begin
            if_id_q <= IF_ID_BUBBLE;
         end
      end
   end

   // Counter saturates so a long-running system never sees it roll back to zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (load_valid && (count_q != CNT_MAX)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign pc_addr_o     = pc;
   assign if_id_pc4_o   = if_id_q.pc4;
   assign if_id_instr_o = if_id_q.instr;
   assign if_id_valid_o = if_id_q.valid;
   assign fetch_count_o = count_q;

endmodule
